// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures the ID control bundle and operands into the
// E stage, flags load-use hazards against the ID instruction and counts the bubbles
// that enter E.
module id_ex_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              validD,
  input  logic              regwriteD,
  input  logic [2:0]        alucD,
  input  logic              alusrcD,
  input  logic              regdstD,
  input  logic              memtoregD,
  input  logic              memwriteD,
  input  logic [1:0]        extopD,
  input  logic              branchD,
  input  logic              memreadD,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [DATA_W-1:0] immD,
  input  logic [DATA_W-1:0] pcplus4D,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rdD,
  output logic              regwriteE,
  output logic [2:0]        alucE,
  output logic              alusrcE,
  output logic              regdstE,
  output logic              memtoregE,
  output logic              memwriteE,
  output logic [1:0]        extopE,
  output logic              branchE,
  output logic              memreadE,
  output logic [DATA_W-1:0] rd1E,
  output logic [DATA_W-1:0] rd2E,
  output logic [DATA_W-1:0] immE,
  output logic [DATA_W-1:0] pcplus4E,
  output logic [REG_AW-1:0] rsE,
  output logic [REG_AW-1:0] rtE,
  output logic [REG_AW-1:0] rdE,
  output logic              validE,
  output logic              lu_hazard,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              regwrite;
    logic [2:0]        aluc;
    logic              alusrc;
    logic              regdst;
    logic              memtoreg;
    logic              memwrite;
    logic [1:0]        extop;
    logic              branch;
    logic              memread;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pcplus4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } slot_t;

  slot_t slot_d;
  slot_t slot_q;
  logic  valid_q;
  logic  bubble_in;

  // Gather the ID-stage bundle into one payload
  always_comb begin
    slot_d          = '0;
    slot_d.regwrite = regwriteD;
    slot_d.aluc     = alucD;
    slot_d.alusrc   = alusrcD;
    slot_d.regdst   = regdstD;
    slot_d.memtoreg = memtoregD;
    slot_d.memwrite = memwriteD;
    slot_d.extop    = extopD;
    slot_d.branch   = branchD;
    slot_d.memread  = memreadD;
    slot_d.rd1      = rd1D;
    slot_d.rd2      = rd2D;
    slot_d.imm      = immD;
    slot_d.pcplus4  = pcplus4D;
    slot_d.rs       = rsD;
    slot_d.rt       = rtD;
    slot_d.rd       = rdD;
  end

  // A bubble enters E on a flush, or on a load of an ID nop
  assign bubble_in = flush | (~stall & ~validD);

  // E-stage slot: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      slot_q  <= slot_d;
      valid_q <= validD;
    end
  end

  // Saturating count of bubbles entering E
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble_in && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign regwriteE = slot_q.regwrite;
  assign alucE     = slot_q.aluc;
  assign alusrcE   = slot_q.alusrc;
  assign regdstE   = slot_q.regdst;
  assign memtoregE = slot_q.memtoreg;
  assign memwriteE = slot_q.memwrite;
  assign extopE    = slot_q.extop;
  assign branchE   = slot_q.branch;
  assign memreadE  = slot_q.memread;
  assign rd1E      = slot_q.rd1;
  assign rd2E      = slot_q.rd2;
  assign immE      = slot_q.imm;
  assign pcplus4E  = slot_q.pcplus4;
  assign rsE       = slot_q.rs;
  assign rtE       = slot_q.rt;
  assign rdE       = slot_q.rd;
  assign validE    = valid_q;

  // Load in E whose destination is read by the ID instruction; uses only
  // registered E state and D indices so it cannot loop through the bubble mux
  assign lu_hazard = valid_q & slot_q.memread & (slot_q.rt != '0) &
                     ((slot_q.rt == rsD) | (slot_q.rt == rtD));

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, validD;
  logic        regwriteD, alusrcD, regdstD, memtoregD, memwriteD, branchD, memreadD;
  logic [2:0]  alucD;
  logic [1:0]  extopD;
  logic [31:0] rd1D, rd2D, immD, pcplus4D;
  logic [4:0]  rsD, rtD, rdD;

  logic        regwriteE, alusrcE, regdstE, memtoregE, memwriteE, branchE, memreadE;
  logic [2:0]  alucE;
  logic [1:0]  extopE;
  logic [31:0] rd1E, rd2E, immE, pcplus4E;
  logic [4:0]  rsE, rtE, rdE;
  logic        validE, lu_hazard;
  logic [15:0] bubble_cnt;

  logic        s_regwriteE, s_alusrcE, s_regdstE, s_memtoregE, s_memwriteE, s_branchE, s_memreadE;
  logic [2:0]  s_alucE;
  logic [1:0]  s_extopE;
  logic [31:0] s_rd1E, s_rd2E, s_immE, s_pcplus4E;
  logic [4:0]  s_rsE, s_rtE, s_rdE;
  logic        s_validE, s_lu_hazard;
  logic [1:0]  s_bubble_cnt;

  logic [154:0] e_all;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign e_all = {regwriteE, alucE, alusrcE, regdstE, memtoregE, memwriteE, extopE,
                  branchE, memreadE, rd1E, rd2E, immE, pcplus4E, rsE, rtE, rdE};

  id_ex_reg u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validD(validD),
    .regwriteD(regwriteD), .alucD(alucD), .alusrcD(alusrcD), .regdstD(regdstD),
    .memtoregD(memtoregD), .memwriteD(memwriteD), .extopD(extopD), .branchD(branchD),
    .memreadD(memreadD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pcplus4D(pcplus4D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .regwriteE(regwriteE), .alucE(alucE), .alusrcE(alusrcE), .regdstE(regdstE),
    .memtoregE(memtoregE), .memwriteE(memwriteE), .extopE(extopE), .branchE(branchE),
    .memreadE(memreadE), .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .pcplus4E(pcplus4E),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .validE(validE), .lu_hazard(lu_hazard),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_reg #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validD(validD),
    .regwriteD(regwriteD), .alucD(alucD), .alusrcD(alusrcD), .regdstD(regdstD),
    .memtoregD(memtoregD), .memwriteD(memwriteD), .extopD(extopD), .branchD(branchD),
    .memreadD(memreadD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .pcplus4D(pcplus4D),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .regwriteE(s_regwriteE), .alucE(s_alucE), .alusrcE(s_alusrcE), .regdstE(s_regdstE),
    .memtoregE(s_memtoregE), .memwriteE(s_memwriteE), .extopE(s_extopE),
    .branchE(s_branchE), .memreadE(s_memreadE), .rd1E(s_rd1E), .rd2E(s_rd2E),
    .immE(s_immE), .pcplus4E(s_pcplus4E), .rsE(s_rsE), .rtE(s_rtE), .rdE(s_rdE),
    .validE(s_validE), .lu_hazard(s_lu_hazard), .bubble_cnt(s_bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    validD = 0; regwriteD = 0; alucD = 0; alusrcD = 0; regdstD = 0; memtoregD = 0;
    memwriteD = 0; extopD = 0; branchD = 0; memreadD = 0;
    rd1D = 0; rd2D = 0; immD = 0; pcplus4D = 0; rsD = 0; rtD = 0; rdD = 0;
  endtask

  task automatic fill_d();
    validD = 1; regwriteD = 1; alucD = 3'b111; alusrcD = 1; regdstD = 1; memtoregD = 1;
    memwriteD = 1; extopD = 2'b11; branchD = 1; memreadD = 1;
    rd1D = 32'hDEAD_BEEF; rd2D = 32'hCAFE_F00D; immD = 32'h0000_FFFF;
    pcplus4D = 32'h0040_0004; rsD = 5'd7; rtD = 5'd7; rdD = 5'd31;
  endtask

  task automatic test_reset();
    fill_d();
    rst = 1; stall = 1; flush = 0;
    tick();
    tick();
    checks++;
    if (e_all !== '0) begin
      errors++; $display("FAIL reset_e_outputs: got %h expected 0", e_all);
    end
    checks++;
    if (validE !== 1'b0 || bubble_cnt !== 16'd0 || s_bubble_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_valid_cnt: got validE=%b cnt=%0d scnt=%0d expected 0/0/0",
               validE, bubble_cnt, s_bubble_cnt);
    end
    checks++;
    if (lu_hazard !== 1'b0) begin
      errors++; $display("FAIL reset_lu_hazard: got %b expected 0", lu_hazard);
    end
    rst = 0; stall = 0;
  endtask

  task automatic test_load();
    clear_d();
    validD = 1; regwriteD = 1; alucD = 3'b010; rd1D = 32'h1234_5678; rsD = 5'd8;
    rd2D = 32'h0BAD_0001; immD = 32'hFFFF_FFF0; pcplus4D = 32'h0000_0104;
    rtD = 5'd3; rdD = 5'd12; extopD = 2'b01;
    tick();
    checks++;
    if (regwriteE !== 1'b1 || alucE !== 3'b010 || rd1E !== 32'h1234_5678 || rsE !== 5'd8) begin
      errors++;
      $display("FAIL load_fields: got rw=%b aluc=%b rd1=%h rs=%0d expected 1/010/12345678/8",
               regwriteE, alucE, rd1E, rsE);
    end
    checks++;
    if (rd2E !== 32'h0BAD_0001 || immE !== 32'hFFFF_FFF0 || pcplus4E !== 32'h0000_0104 ||
        rtE !== 5'd3 || rdE !== 5'd12 || extopE !== 2'b01 || memreadE !== 1'b0) begin
      errors++;
      $display("FAIL load_other: got rd2=%h imm=%h pc4=%h rt=%0d rd=%0d ext=%b mr=%b",
               rd2E, immE, pcplus4E, rtE, rdE, extopE, memreadE);
    end
    checks++;
    if (validE !== 1'b1 || bubble_cnt !== 16'd0) begin
      errors++;
      $display("FAIL load_valid_cnt: got validE=%b cnt=%0d expected 1/0", validE, bubble_cnt);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      fill_d();
      validD = 1'(i % 2);
      rd1D = 32'hA000_0000 + 32'(i);
      tick();
      checks++;
      if (regwriteE !== 1'b1 || alucE !== 3'b010 || rd1E !== 32'h1234_5678 ||
          rsE !== 5'd8 || memreadE !== 1'b0 || validE !== 1'b1 || bubble_cnt !== 16'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got aluc=%b rd1=%h rs=%0d mr=%b validE=%b cnt=%0d",
                 i, alucE, rd1E, rsE, memreadE, validE, bubble_cnt);
      end
    end
    flush = 1;
    tick();
    checks++;
    if (e_all !== '0 || validE !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall: got e=%h validE=%b expected 0/0", e_all, validE);
    end
    checks++;
    if (bubble_cnt !== 16'd1 || s_bubble_cnt !== 2'd1) begin
      errors++;
      $display("FAIL flush_count: got cnt=%0d scnt=%0d expected 1/1", bubble_cnt, s_bubble_cnt);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_load_use();
    clear_d();
    validD = 1; memreadD = 1; memtoregD = 1; regwriteD = 1; rtD = 5'd9; rsD = 5'd1;
    tick();
    rsD = 5'd9; rtD = 5'd3;
    #1;
    checks++;
    if (lu_hazard !== 1'b1) begin
      errors++; $display("FAIL lu_rs_match: got %b expected 1", lu_hazard);
    end
    rsD = 5'd0; rtD = 5'd9;
    #1;
    checks++;
    if (lu_hazard !== 1'b1) begin
      errors++; $display("FAIL lu_rt_match: got %b expected 1", lu_hazard);
    end
    rsD = 5'd10; rtD = 5'd10;
    #1;
    checks++;
    if (lu_hazard !== 1'b0) begin
      errors++; $display("FAIL lu_no_match: got %b expected 0", lu_hazard);
    end
    rsD = 5'd0; rtD = 5'd0;
    tick();
    #1;
    checks++;
    if (lu_hazard !== 1'b0 || rtE !== 5'd0 || memreadE !== 1'b1) begin
      errors++;
      $display("FAIL lu_r0_dest: got lu=%b rtE=%0d mr=%b expected 0/0/1", lu_hazard, rtE, memreadE);
    end
    memreadD = 0; memtoregD = 0; rtD = 5'd9;
    tick();
    rsD = 5'd9;
    #1;
    checks++;
    if (lu_hazard !== 1'b0) begin
      errors++; $display("FAIL lu_not_load: got %b expected 0", lu_hazard);
    end
  endtask

  task automatic test_nop_load();
    rst = 1;
    tick();
    rst = 0;
    clear_d();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (validE !== 1'b0 || bubble_cnt !== 16'(i) || s_bubble_cnt !== 2'((i > 3) ? 3 : i)) begin
        errors++;
        $display("FAIL nop_count[%0d]: got validE=%b cnt=%0d scnt=%0d expected 0/%0d/%0d",
                 i, validE, bubble_cnt, s_bubble_cnt, i, (i > 3) ? 3 : i);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_d();
    validD = 1; memreadD = 1; memtoregD = 1; regwriteD = 1; alusrcD = 1;
    rsD = 5'd4; rtD = 5'd9; immD = 32'h0000_0010;
    tick();
    stall = 1; clear_d();
    tick();
    rsD = 5'd9;
    #1;
    checks++;
    if (lu_hazard !== 1'b1 || validE !== 1'b1 || bubble_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_lw_held: got lu=%b validE=%b cnt=%0d expected 1/1/5",
               lu_hazard, validE, bubble_cnt);
    end
    rst = 1;
    tick();
    checks++;
    if (e_all !== '0 || validE !== 1'b0 || bubble_cnt !== 16'd0 || lu_hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: got e=%h validE=%b cnt=%0d lu=%b expected 0",
               e_all, validE, bubble_cnt, lu_hazard);
    end
    rst = 0; stall = 0;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    clear_d();
    test_reset();
    test_load();
    test_stall();
    test_load_use();
    test_nop_load();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
